// File: rtl/replay_buffer.sv
// Operand replay buffer: loads len_i RD_WIDTH words from WR_WIDTH beats, then replays them for passes_i passes.
// Words readable one cycle after their write beat; valid/ready on both sides, one beat and one word per cycle.
module replay_buffer #(
   parameter int WR_WIDTH = 128,
   parameter int RD_WIDTH = 32,
   parameter int DEPTH    = 16,
   parameter int RATIO    = WR_WIDTH / RD_WIDTH,
   parameter int AW       = $clog2(DEPTH),
   parameter int CW       = $clog2(DEPTH + 1)
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                flush_i,
   input  logic                start_i,
   input  logic [CW-1:0]       len_i,
   input  logic [7:0]          passes_i,
   input  logic                wr_valid_i,
   output logic                wr_ready_o,
   input  logic [WR_WIDTH-1:0] wr_data_i,
   output logic                rd_valid_o,
   input  logic                rd_ready_i,
   output logic [RD_WIDTH-1:0] rd_data_o,
   output logic                rd_last_o,
   output logic                rd_final_o,
   output logic                busy_o,
   output logic                loaded_o,
   output logic [7:0]          pass_cnt_o
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_REPLAY = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [CW-1:0]       r_len;
   logic [CW-1:0]       r_wr_cnt;
   logic [7:0]          r_passes;
   logic [7:0]          r_pass_cnt;
   logic [AW-1:0]       r_rd_ptr;
   logic [RD_WIDTH-1:0] r_mem [DEPTH];

   logic                w_start;
   logic                w_wr_hs;
   logic                w_rd_hs;
   logic                w_rd_wrap;
   logic [CW-1:0]       w_len_m1;
   logic [CW:0]         w_wr_sum;
   logic [CW-1:0]       w_wr_cnt_nxt;
   logic [CW-1:0]       w_wpos [RATIO];

   assign w_start   = (r_state == ST_IDLE) && start_i && (len_i != '0);
   assign w_wr_hs   = wr_valid_i && wr_ready_o;
   assign w_rd_hs   = rd_valid_o && rd_ready_i;
   assign w_len_m1  = r_len - CW'(1);
   assign w_rd_wrap = (CW'(r_rd_ptr) == w_len_m1);

   // A short final beat saturates the write count at the programmed length.
   assign w_wr_sum     = {1'b0, r_wr_cnt} + (CW+1)'(RATIO);
   assign w_wr_cnt_nxt = (w_wr_sum > {1'b0, r_len}) ? r_len : w_wr_sum[CW-1:0];

   always_comb begin
      for (int k = 0; k < RATIO; k++) begin
         w_wpos[k] = r_wr_cnt + CW'(k);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (flush_i) begin
         w_state_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_start) w_state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
               if (w_rd_hs && rd_final_o)
                  w_state_nxt = ST_IDLE;
               else if (w_wr_hs && (w_wr_cnt_nxt == r_len))
                  w_state_nxt = ST_REPLAY;
            end
            ST_REPLAY: begin
               if (w_rd_hs && rd_final_o) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      wr_ready_o = 1'b0;
      rd_valid_o = 1'b0;
      busy_o     = 1'b0;
      loaded_o   = 1'b0;
      case (r_state)
         ST_LOAD: begin
            wr_ready_o = (r_wr_cnt < r_len);
            rd_valid_o = (CW'(r_rd_ptr) < r_wr_cnt);
            busy_o     = 1'b1;
         end
         ST_REPLAY: begin
            rd_valid_o = 1'b1;
            busy_o     = 1'b1;
            loaded_o   = 1'b1;
         end
         default: ;
      endcase
      rd_last_o  = rd_valid_o && w_rd_wrap;
      rd_final_o = rd_last_o && (r_passes != 8'd0) && (r_pass_cnt == r_passes - 8'd1);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni || flush_i) begin
         r_len      <= '0;
         r_passes   <= '0;
         r_wr_cnt   <= '0;
         r_rd_ptr   <= '0;
         r_pass_cnt <= '0;
      end else if (w_start) begin
         r_len      <= len_i;
         r_passes   <= passes_i;
         r_wr_cnt   <= '0;
         r_rd_ptr   <= '0;
         r_pass_cnt <= '0;
      end else begin
         if (w_wr_hs) r_wr_cnt <= w_wr_cnt_nxt;
         if (w_rd_hs) begin
            if (w_rd_wrap) begin
               r_rd_ptr   <= '0;
               r_pass_cnt <= r_pass_cnt + 8'd1;
            end else begin
               r_rd_ptr   <= r_rd_ptr + AW'(1);
            end
         end
      end
   end

   // Flush wins over a coincident write beat, so storage is untouched by it.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (w_wr_hs && !flush_i) begin
         for (int k = 0; k < RATIO; k++) begin
            if (w_wpos[k] < r_len)
               r_mem[AW'(w_wpos[k])] <= wr_data_i[k*RD_WIDTH +: RD_WIDTH];
         end
      end
   end

   assign rd_data_o  = r_mem[r_rd_ptr];
   assign pass_cnt_o = r_pass_cnt;

endmodule
